// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator (stage 0 of the display pipeline)
//
// Purpose: free-running horizontal/vertical counters gated by en. Every output
// is decoded from the current counters and registered on the same edge, so all
// outputs are mutually aligned and lag the counters by one cycle.
//
// Ports:
//   pclk        in   pixel clock, rising edge
//   reset       in   asynchronous active-high reset
//   en          in   count enable; 0 freezes counters and all outputs
//   DE_s0       out  display enable, high in the visible area
//   h_sync_s0   out  horizontal sync, polarity set by SYNC_ACTIVE_LOW
//   v_sync_s0   out  vertical sync, polarity set by SYNC_ACTIVE_LOW
//   x_pixel_s0  out  horizontal position 0..H_TOTAL-1
//   y_pixel_s0  out  vertical position 0..V_TOTAL-1
//   line_start  out  high while x_pixel_s0 == 0
//   frame_start out  high while x_pixel_s0 == 0 and y_pixel_s0 == 0
module vga_timing_gen #(
    parameter int H_VISIBLE       = 640,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_VISIBLE       = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       en,
    output logic       DE_s0,
    output logic       h_sync_s0,
    output logic       v_sync_s0,
    output logic [9:0] x_pixel_s0,
    output logic [9:0] y_pixel_s0,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
    endgenerate

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
    // Idle (inactive) sync level; the active level is its complement.
    localparam logic       SYNC_IDLE  = (SYNC_ACTIVE_LOW != 0);

    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;

    logic w_h_wrap;
    logic w_v_wrap;
    logic w_de;
    logic w_hs_act;
    logic w_vs_act;

    assign w_h_wrap = (r_h_cnt == H_LAST);
    assign w_v_wrap = (r_v_cnt == V_LAST);
    assign w_de     = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
    assign w_hs_act = (r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST);
    // Vertical sync looks at v_cnt only, so it covers whole lines.
    assign w_vs_act = (r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST);

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_h_cnt <= 10'd0;
            r_v_cnt <= 10'd0;
        end else if (en) begin
            if (w_h_wrap) begin
                r_h_cnt <= 10'd0;
                r_v_cnt <= w_v_wrap ? 10'd0 : r_v_cnt + 10'd1;
            end else begin
                r_h_cnt <= r_h_cnt + 10'd1;
            end
        end
    end

    // Decode from the pre-increment counters; strobes also freeze while en=0.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            DE_s0       <= 1'b0;
            h_sync_s0   <= SYNC_IDLE;
            v_sync_s0   <= SYNC_IDLE;
            x_pixel_s0  <= 10'd0;
            y_pixel_s0  <= 10'd0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            DE_s0       <= w_de;
            h_sync_s0   <= w_hs_act ? ~SYNC_IDLE : SYNC_IDLE;
            v_sync_s0   <= w_vs_act ? ~SYNC_IDLE : SYNC_IDLE;
            x_pixel_s0  <= r_h_cnt;
            y_pixel_s0  <= r_v_cnt;
            line_start  <= (r_h_cnt == 10'd0);
            frame_start <= (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    logic pclk;
    logic reset;
    logic en;

    // a: small raster, sync active low; b: same raster, sync active high;
    // c: default 640x480 timing.
    logic       de_a, hs_a, vs_a, ls_a, fs_a;
    logic [9:0] x_a, y_a;
    logic       de_b, hs_b, vs_b, ls_b, fs_b;
    logic [9:0] x_b, y_b;
    logic       de_c, hs_c, vs_c, ls_c, fs_c;
    logic [9:0] x_c, y_c;

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_VISIBLE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_ACTIVE_LOW(1)
    ) dut_a (
        .pclk(pclk), .reset(reset), .en(en),
        .DE_s0(de_a), .h_sync_s0(hs_a), .v_sync_s0(vs_a),
        .x_pixel_s0(x_a), .y_pixel_s0(y_a),
        .line_start(ls_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_VISIBLE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_ACTIVE_LOW(0)
    ) dut_b (
        .pclk(pclk), .reset(reset), .en(en),
        .DE_s0(de_b), .h_sync_s0(hs_b), .v_sync_s0(vs_b),
        .x_pixel_s0(x_b), .y_pixel_s0(y_b),
        .line_start(ls_b), .frame_start(fs_b)
    );

    vga_timing_gen dut_c (
        .pclk(pclk), .reset(reset), .en(en),
        .DE_s0(de_c), .h_sync_s0(hs_c), .v_sync_s0(vs_c),
        .x_pixel_s0(x_c), .y_pixel_s0(y_c),
        .line_start(ls_c), .frame_start(fs_c)
    );

    logic [24:0] out_a, out_b, out_c;
    assign out_a = {de_a, hs_a, vs_a, ls_a, fs_a, x_a, y_a};
    assign out_b = {de_b, hs_b, vs_b, ls_b, fs_b, x_b, y_b};
    assign out_c = {de_c, hs_c, vs_c, ls_c, fs_c, x_c, y_c};

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_tests = 0;
    int n_fail  = 0;
    longint n_edges = 0;  // enabled edges since the last reset

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected outputs after `cnt` enabled edges: raster position is simply the
    // (cnt-1)-th pixel of an endless sequence of frames.
    function automatic logic [24:0] model(input longint cnt,
                                          input int hv, input int hf, input int hs, input int hb,
                                          input int vv, input int vf, input int vs, input int vb,
                                          input bit sal);
        longint ht, vt, p, h, v;
        logic de, hsy, vsy, ls, fs;
        if (cnt == 0) return {1'b0, sal, sal, 1'b0, 1'b0, 10'd0, 10'd0};
        ht  = hv + hf + hs + hb;
        vt  = vv + vf + vs + vb;
        p   = cnt - 1;
        h   = p % ht;
        v   = (p / ht) % vt;
        de  = (h < hv) && (v < vv);
        hsy = (h >= hv + hf && h < hv + hf + hs) ? !sal : sal;
        vsy = (v >= vv + vf && v < vv + vf + vs) ? !sal : sal;
        ls  = (h == 0);
        fs  = (h == 0) && (v == 0);
        return {de, hsy, vsy, ls, fs, 10'(h), 10'(v)};
    endfunction

    task automatic check_dut(input string nm, input logic [24:0] got, input logic [24:0] exp);
        chk({nm, ".de"},  32'(got[24]),    32'(exp[24]));
        chk({nm, ".hs"},  32'(got[23]),    32'(exp[23]));
        chk({nm, ".vs"},  32'(got[22]),    32'(exp[22]));
        chk({nm, ".ls"},  32'(got[21]),    32'(exp[21]));
        chk({nm, ".fs"},  32'(got[20]),    32'(exp[20]));
        chk({nm, ".x"},   32'(got[19:10]), 32'(exp[19:10]));
        chk({nm, ".y"},   32'(got[9:0]),   32'(exp[9:0]));
    endtask

    task automatic check_all();
        check_dut("a", out_a, model(n_edges, 16, 2, 4, 3, 10, 2, 2, 3, 1'b1));
        check_dut("b", out_b, model(n_edges, 16, 2, 4, 3, 10, 2, 2, 3, 1'b0));
        check_dut("c", out_c, model(n_edges, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1));
    endtask

    // Asynchronous reset pulse placed between clock edges; outputs must show
    // reset values before the next rising edge.
    task automatic async_reset_pulse();
        #2 reset = 1'b1;
        #1;
        n_edges = 0;
        check_all();
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        repeat (3) @(negedge pclk);
        check_all();
        chk("rst.c.hs", 32'(hs_c), 32'd1);
        chk("rst.b.vs", 32'(vs_b), 32'd0);
        reset = 1'b0;
        en    = 1'b1;
        @(posedge pclk);
        n_edges++;
        @(negedge pclk);
        chk("first.de", 32'(de_c), 32'd1);
        chk("first.x",  32'(x_c),  32'd0);
        chk("first.y",  32'(y_c),  32'd0);
        chk("first.ls", 32'(ls_c), 32'd1);
        chk("first.fs", 32'(fs_c), 32'd1);
        check_all();

        for (int i = 0; i < 3000; i++) begin
            if (i == 40 || i == 1700 || $urandom_range(0, 999) == 0)
                async_reset_pulse();
            if ((i >= 300 && i < 350) || (i >= 2500 && i < 2530))
                en = 1'b0;
            else
                en = ($urandom_range(0, 3) != 0);
            @(posedge pclk);
            if (en) n_edges++;
            @(negedge pclk);
            check_all();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
